ram_access_sequencer: RTL and testbench

- Initiator side of the simulation RAM port: core-facing request/response engine that drives a byte-wide asynchronous RAM (separate read/write address, write data, write enable, combinational read data).
- Splits 16-bit core loads/stores into little-endian byte transfers: low byte at Addr, high byte at Addr+1.
- Sequences the RAM write strobe so that address and data are stable before the enable rises.
- Sits between the core's load/store stage and the RAM model.

---
 rtl/ram_access_sequencer_pkg.sv | 36 +++
 rtl/ram_access_sequencer.sv | 141 ++++++++++++++
 tb/tb_ram_access_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_sequencer_pkg.sv
// Shared types and constants for the byte-wide RAM access sequencer.
// Holds the FSM state encoding, response kinds and default widths.
package ram_access_sequencer_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
    localparam int unsigned DEFAULT_WORD_WIDTH = 8;
    localparam int unsigned CORE_WIDTH         = 2 * DEFAULT_WORD_WIDTH;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_LO     = 3'd1;
    localparam logic [2:0] S_RD_HI     = 3'd2;
    localparam logic [2:0] S_WR_LO_SET = 3'd3;
    localparam logic [2:0] S_WR_LO_STB = 3'd4;
    localparam logic [2:0] S_WR_HI_SET = 3'd5;
    localparam logic [2:0] S_WR_HI_STB = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        RD_LO     = S_RD_LO,
        RD_HI     = S_RD_HI,
        WR_LO_SET = S_WR_LO_SET,
        WR_LO_STB = S_WR_LO_STB,
        WR_HI_SET = S_WR_HI_SET,
        WR_HI_STB = S_WR_HI_STB
    } state_e;

    typedef enum logic {
        RESP_STORE = 1'b0,
        RESP_LOAD  = 1'b1
    } resp_e;

    function automatic int unsigned core_width(input int unsigned word_width);
        return 2 * word_width;
    endfunction

endpackage

// File: rtl/ram_access_sequencer.sv
// Core-facing load/store engine that splits 16-bit accesses into little-endian
// byte transfers on an asynchronous byte-wide RAM with a setup-then-strobe write.
module ram_access_sequencer
    import ram_access_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic                    ReqByte,
    input  logic [ADDR_WIDTH-1:0]   ReqAddr,
    input  logic [2*WORD_WIDTH-1:0] ReqWData,
    output logic                    RespValid,
    output logic [2*WORD_WIDTH-1:0] RespRData,
    output logic                    RamWriteEnable,
    output logic [ADDR_WIDTH-1:0]   RamReadAddr,
    output logic [ADDR_WIDTH-1:0]   RamWriteAddr,
    output logic [WORD_WIDTH-1:0]   RamWriteData,
    input  logic [WORD_WIDTH-1:0]   RamReadData
);

    localparam int unsigned CW = core_width(WORD_WIDTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    // Holds the captured low read byte on loads, the pending high write byte on stores
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  is_byte_q, is_byte_d;
    logic                  we_q, we_d;
    logic                  rv_q, rv_d;
    logic [CW-1:0]         rdata_q, rdata_d;
    logic                  ready_q, ready_d;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;
        is_byte_d = is_byte_q;
        we_d      = 1'b0;
        rv_d      = 1'b0;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    addr_d    = ReqAddr;
                    is_byte_d = ReqByte;
                    if (ReqWrite) begin
                        wdata_d = ReqWData[WORD_WIDTH-1:0];
                        buf_d   = ReqWData[CW-1:WORD_WIDTH];
                        state_d = WR_LO_SET;
                    end else begin
                        state_d = RD_LO;
                    end
                end
            end
            RD_LO: begin
                if (is_byte_q) begin
                    rdata_d = {{WORD_WIDTH{1'b0}}, RamReadData};
                    rv_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    buf_d   = RamReadData;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                rdata_d = {RamReadData, buf_q};
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            WR_LO_SET: begin
                we_d    = 1'b1;
                state_d = WR_LO_STB;
            end
            WR_LO_STB: begin
                if (is_byte_q) begin
                    rv_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    wdata_d = buf_q;
                    state_d = WR_HI_SET;
                end
            end
            WR_HI_SET: begin
                we_d    = 1'b1;
                state_d = WR_HI_STB;
            end
            WR_HI_STB: begin
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            is_byte_q <= 1'b0;
            we_q      <= 1'b0;
            rv_q      <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            buf_q     <= buf_d;
            is_byte_q <= is_byte_d;
            we_q      <= we_d;
            rv_q      <= rv_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
        end
    end

    assign ReqReady       = ready_q;
    assign RespValid      = rv_q;
    assign RespRData      = rdata_q;
    assign RamWriteEnable = we_q;
    assign RamReadAddr    = addr_q;
    assign RamWriteAddr   = addr_q;
    assign RamWriteData   = wdata_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Directed bench for ram_access_sequencer driving a byte-wide asynchronous RAM model.
module tb_ram_access_sequencer;

    logic        Clock;
    logic        nReset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic        ReqByte;
    logic [7:0]  ReqAddr;
    logic [15:0] ReqWData;
    logic        RespValid;
    logic [15:0] RespRData;
    logic        RamWriteEnable;
    logic [7:0]  RamReadAddr;
    logic [7:0]  RamWriteAddr;
    logic [7:0]  RamWriteData;
    logic [7:0]  RamReadData;

    int tests = 0;
    int fails = 0;

    ram_access_sequencer #(.ADDR_WIDTH(8), .WORD_WIDTH(8)) dut (
        .Clock          (Clock),
        .nReset         (nReset),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .ReqWrite       (ReqWrite),
        .ReqByte        (ReqByte),
        .ReqAddr        (ReqAddr),
        .ReqWData       (ReqWData),
        .RespValid      (RespValid),
        .RespRData      (RespRData),
        .RamWriteEnable (RamWriteEnable),
        .RamReadAddr    (RamReadAddr),
        .RamWriteAddr   (RamWriteAddr),
        .RamWriteData   (RamWriteData),
        .RamReadData    (RamReadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM responder: combinational read, write while strobe is high; preloaded with addr ^ 0x3C
    logic [7:0] mem [256];
    logic       mem_init;
    assign RamReadData = mem[RamReadAddr];
    always @(posedge Clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (RamWriteEnable) begin
            mem[RamWriteAddr] <= RamWriteData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe must rise only on stable address/data and last exactly one cycle
    logic       prev_we;
    logic [7:0] prev_wa, prev_wd;
    initial prev_we = 1'b0;
    always @(negedge Clock) begin
        if (RamWriteEnable === 1'b1) begin
            chk("strobe_one_cycle", 32'(prev_we), 32'd0);
            chk("strobe_addr_stable", 32'(RamWriteAddr), 32'(prev_wa));
            chk("strobe_data_stable", 32'(RamWriteData), 32'(prev_wd));
        end
        prev_we = RamWriteEnable;
        prev_wa = RamWriteAddr;
        prev_wd = RamWriteData;
    end

    // Drive one request, wait for its response; lat = edges from accept to RespValid
    task automatic issue(input logic w, input logic b, input logic [7:0] a,
                         input logic [15:0] d, output int lat);
        ReqValid = 1'b1; ReqWrite = w; ReqByte = b; ReqAddr = a; ReqWData = d;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        lat = 0;
        while (RespValid !== 1'b1 && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    int lat;
    int rv_seen;

    initial begin
        nReset = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0;
        ReqAddr = 8'h00; ReqWData = 16'h0000; mem_init = 1'b1;
        @(posedge Clock); #1;
        mem_init = 1'b0;
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_respvalid", 32'(RespValid), 32'd0);
        chk("rst_rdata", 32'(RespRData), 32'h0);
        chk("rst_we", 32'(RamWriteEnable), 32'd0);
        chk("rst_raddr", 32'(RamReadAddr), 32'h0);
        chk("rst_waddr", 32'(RamWriteAddr), 32'h0);
        chk("rst_wdata", 32'(RamWriteData), 32'h0);
        nReset = 1'b1;
        @(posedge Clock); #1;

        // 1: word store then word load
        issue(1'b1, 1'b0, 8'h10, 16'hBEEF, lat);
        chk("t1_st_lat", 32'(lat), 32'd4);
        chk("t1_st_ready", 32'(ReqReady), 32'd1);
        chk("t1_mem10", 32'(mem[8'h10]), 32'hEF);
        chk("t1_mem11", 32'(mem[8'h11]), 32'hBE);
        issue(1'b0, 1'b0, 8'h10, 16'h0000, lat);
        chk("t1_ld_lat", 32'(lat), 32'd2);
        chk("t1_ld_data", 32'(RespRData), 32'hBEEF);
        @(posedge Clock); #1;
        chk("t1_rv_pulse", 32'(RespValid), 32'd0);
        chk("t1_idle_we", 32'(RamWriteEnable), 32'd0);

        // 2: byte store then byte load; stores leave RespRData alone
        issue(1'b1, 1'b1, 8'h20, 16'h775A, lat);
        chk("t2_st_lat", 32'(lat), 32'd2);
        chk("t2_rdata_hold", 32'(RespRData), 32'hBEEF);
        chk("t2_mem20", 32'(mem[8'h20]), 32'h5A);
        chk("t2_mem21", 32'(mem[8'h21]), 32'h1D);
        issue(1'b0, 1'b1, 8'h20, 16'h0000, lat);
        chk("t2_ld_lat", 32'(lat), 32'd1);
        chk("t2_ld_data", 32'(RespRData), 32'h005A);

        // 3: word access at the top address wraps to 0
        issue(1'b1, 1'b0, 8'hFF, 16'h1234, lat);
        chk("t3_st_lat", 32'(lat), 32'd4);
        chk("t3_memff", 32'(mem[8'hFF]), 32'h34);
        chk("t3_mem00", 32'(mem[8'h00]), 32'h12);
        issue(1'b0, 1'b0, 8'hFF, 16'h0000, lat);
        chk("t3_ld_data", 32'(RespRData), 32'h1234);
        chk("t3_raddr_wrap", 32'(RamReadAddr), 32'h00);

        // 4: back-to-back loads with ReqValid held high
        ReqValid = 1'b1; ReqWrite = 1'b0;
        ReqByte = 1'b0; ReqAddr = 8'h10;
        @(posedge Clock); #1;
        ReqAddr = 8'h77;
        lat = 0;
        while (RespValid !== 1'b1 && lat < 20) begin @(posedge Clock); #1; lat++; end
        chk("t4_a_lat", 32'(lat), 32'd2);
        chk("t4_a_data", 32'(RespRData), 32'hBEEF);
        chk("t4_a_ready", 32'(ReqReady), 32'd1);
        ReqByte = 1'b1; ReqAddr = 8'h20;
        @(posedge Clock); #1;
        lat = 0;
        while (RespValid !== 1'b1 && lat < 20) begin @(posedge Clock); #1; lat++; end
        chk("t4_b_lat", 32'(lat), 32'd1);
        chk("t4_b_data", 32'(RespRData), 32'h005A);
        chk("t4_b_ready", 32'(ReqReady), 32'd1);
        ReqByte = 1'b0; ReqAddr = 8'hFF;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        lat = 0;
        while (RespValid !== 1'b1 && lat < 20) begin @(posedge Clock); #1; lat++; end
        chk("t4_c_lat", 32'(lat), 32'd2);
        chk("t4_c_data", 32'(RespRData), 32'h1234);
        @(posedge Clock); #1;

        // 6a: reset while the low strobe is high drops it at once
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b0; ReqAddr = 8'h50; ReqWData = 16'h1111;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        @(posedge Clock); #1;
        chk("t6a_we_hi", 32'(RamWriteEnable), 32'd1);
        nReset = 1'b0;
        #1;
        chk("t6a_we_drop", 32'(RamWriteEnable), 32'd0);
        chk("t6a_ready", 32'(ReqReady), 32'd1);
        @(posedge Clock); #1;
        nReset = 1'b1;
        chk("t6a_mem51", 32'(mem[8'h51]), 32'h6D);
        issue(1'b0, 1'b1, 8'h20, 16'h0000, lat);
        chk("t6a_after_lat", 32'(lat), 32'd1);
        chk("t6a_after_data", 32'(RespRData), 32'h005A);

        // 6b: reset during WR_HI_SET of a word store
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b0; ReqAddr = 8'h40; ReqWData = 16'hCAFE;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        chk("t6b_hiset_addr", 32'(RamWriteAddr), 32'h41);
        chk("t6b_hiset_data", 32'(RamWriteData), 32'hCA);
        nReset = 1'b0;
        #1;
        chk("t6b_we", 32'(RamWriteEnable), 32'd0);
        chk("t6b_rv", 32'(RespValid), 32'd0);
        chk("t6b_ready", 32'(ReqReady), 32'd1);
        chk("t6b_waddr", 32'(RamWriteAddr), 32'h0);
        chk("t6b_rdata", 32'(RespRData), 32'h0);
        @(posedge Clock); #1;
        chk("t6b_we_held", 32'(RamWriteEnable), 32'd0);
        nReset = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock); #1;
            if (RespValid === 1'b1) rv_seen++;
        end
        chk("t6b_no_resp", 32'(rv_seen), 32'd0);
        chk("t6b_ready_after", 32'(ReqReady), 32'd1);
        chk("t6b_mem40", 32'(mem[8'h40]), 32'hFE);
        chk("t6b_mem41", 32'(mem[8'h41]), 32'h7D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
